gmii_rx_frame_parser: RTL and testbench
=======================================

Name: gmii_rx_frame_parser

Overview:
- Consumes the byte-wide GMII receive stream produced by the RGMII/GMII converter and delineates Ethernet frames.
- Strips preamble and SFD, then checks FCS (CRC-32), length and rx_er.
- Emits a payload byte stream with FCS removed, plus sop/eop markers and a per-frame status on the eop beat.
- Sits between the PHY interface converter and the MAC/packet-processing logic, entirely in the gmii_rx_clk domain.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (destination address through FCS inclusive).
- MAX_LEN, 1518, maximum legal frame length in bytes (inclusive).

Ports:
- gmii_rx_clk  in  1  receive byte clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- gmii_rxd  in  8  received byte.
- gmii_rx_dv  in  1  receive data valid.
- gmii_rx_er  in  1  receive error.
- out_valid  out  1  payload byte valid; single-cycle beats, no backpressure.
- out_data  out  8  payload byte.
- out_sop  out  1  first payload byte of frame.
- out_eop  out  1  last payload byte (the byte before FCS).
- out_err  out  1  frame bad; meaningful only when out_eop=1.
- out_len  out  11  payload length (frame length minus 4), saturating; meaningful only when out_eop=1.
- frame_ok  out  1  one-cycle pulse: frame accepted without error.
- frame_bad  out  1  one-cycle pulse: frame ended with an error, or was dropped.

Behaviour:
- Reset (synchronous, gmii_rx_clk):
  - All outputs go to 0, state goes to IDLE, the byte pipe is emptied, counters clear.
  - A frame in progress when reset asserts is discarded silently: no eop, no pulse.
  - Downstream must tolerate an sop with no matching eop.
- States: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: with rx_dv=1, 0x55 goes to PREAMBLE, 0xD5 goes to DATA (short preamble accepted), any other byte goes to DROP.
  - PREAMBLE: rx_dv=1 and 0x55 stays in PREAMBLE; 0xD5 goes to DATA; any other byte goes to DROP. rx_dv=0 goes to IDLE with no pulses.
  - DATA: every rx_dv=1 byte enters the byte pipe and the CRC, and increments the byte count. rx_dv=0 ends the frame and returns to IDLE.
  - DROP: waits for rx_dv=0, then goes to IDLE and pulses frame_bad for one cycle in the cycle after rx_dv is sampled low. Nothing is emitted.
  - rx_er seen in IDLE or PREAMBLE forces DROP.
- CRC:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte processed LSB first.
  - Covers every DATA byte, including the FCS bytes.
  - Frame is CRC-good when the register equals residue 0xDEBB20E3 after the last byte.
  - CRC is reinitialised on SFD detection.
- Byte count: 11 bits, saturates at 2047.
- Byte pipe (5 deep):
  - While rx_dv=1 in DATA, a new byte arriving when 5 bytes are already held pushes the oldest byte out.
  - The pushed-out byte is registered onto out_data with out_valid=1 in the next cycle.
  - The first such beat of a frame carries out_sop=1.
- End of frame: in the cycle after rx_dv is first sampled 0 in DATA:
  - Count ≥ 5: the oldest held byte is emitted with out_valid=1 and out_eop=1 (with out_sop=1 too if the count is exactly 5).
  - The remaining 4 held bytes (the FCS) are discarded.
  - out_len = count − 4.
  - out_err = crc_bad | len_err | rx_er_seen, where len_err = (count < MIN_LEN) | (count > MAX_LEN).
  - Exactly one of frame_ok or frame_bad pulses in the same cycle.
  - Count < 5: no beat is emitted and frame_bad pulses.
- Latency: a payload byte sampled at cycle t appears on out_data at t+6 while rx_dv stays high (5 pipe stages plus 1 output register).
- gmii_rx_er during DATA sets rx_er_seen, and the frame continues to be forwarded.
- A 1-cycle gap between frames is supported: the eop beat of frame N coincides with the IDLE decode of frame N+1's first preamble byte, and neither is lost.
- Outputs not asserted in a given cycle are 0. out_data holds its value when out_valid=0.

Test Plan:
- Good frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B plus a correct FCS → 60 beats 0x00..0x3B, sop on 0x00, eop on 0x3B, out_len=60, out_err=0, frame_ok pulses once.
- Same frame with FCS byte 0 XOR 0x01 → identical data beats, eop with out_err=1, frame_bad pulse, no frame_ok.
- Good frame with gmii_rx_er=1 on payload byte 10 → all bytes forwarded, eop with out_err=1, frame_bad pulse.
- Runt: 40-byte payload plus valid FCS → eop with out_len=40, out_err=1. 3-byte post-SFD burst → no beats, frame_bad pulse only.
- Bad preamble: 0x55,0x55,0xA5,… with rx_dv held for 20 cycles → no out_valid, one frame_bad pulse after rx_dv falls.
- Two good 64-byte frames separated by 1 idle cycle → two complete sop..eop sequences, two frame_ok pulses.
- Reset asserted mid-payload → outputs 0 the next cycle, no eop, no pulse; a following good frame is parsed normally.

Source files
------------

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame delineation: strips preamble/SFD, checks FCS, length and rx_er,
// and forwards the payload (FCS removed) with sop/eop markers and a per-frame status.
module gmii_rx_frame_parser #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [10:0] out_len,
  output logic        frame_ok,
  output logic        frame_bad
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREAMBLE = 2'd1;
  localparam logic [1:0] DATA     = 2'd2;
  localparam logic [1:0] DROP     = 2'd3;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] PIPE_DEPTH  = 11'd5;

  logic [1:0]  state;
  logic [7:0]  pipe [5];
  logic [31:0] crc;
  logic [10:0] byte_cnt;
  logic        rx_er_seen;
  logic        sop_pending;

  logic        sfd_hit;
  logic        frame_err;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    sfd_hit   = gmii_rx_dv && !gmii_rx_er && (gmii_rxd == SFD_BYTE) &&
                ((state == IDLE) || (state == PREAMBLE));
    frame_err = (crc != CRC_RESIDUE) || (byte_cnt < MIN_L) || (byte_cnt > MAX_L) || rx_er_seen;
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      state       <= IDLE;
      for (int unsigned i = 0; i < 5; i++) pipe[i] <= '0;
      crc         <= '1;
      byte_cnt    <= '0;
      rx_er_seen  <= 1'b0;
      sop_pending <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_err     <= 1'b0;
      out_len     <= '0;
      frame_ok    <= 1'b0;
      frame_bad   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= '0;
      frame_ok  <= 1'b0;
      frame_bad <= 1'b0;

      case (state)
        IDLE: begin
          if (gmii_rx_dv) begin
            if (gmii_rx_er)                state <= DROP;
            else if (gmii_rxd == PRE_BYTE) state <= PREAMBLE;
            else if (gmii_rxd == SFD_BYTE) state <= DATA;
            else                           state <= DROP;
          end
        end

        PREAMBLE: begin
          if (!gmii_rx_dv)               state <= IDLE;
          else if (gmii_rx_er)           state <= DROP;
          else if (gmii_rxd == PRE_BYTE) state <= PREAMBLE;
          else if (gmii_rxd == SFD_BYTE) state <= DATA;
          else                           state <= DROP;
        end

        DATA: begin
          if (gmii_rx_dv) begin
            crc <= crc_byte(crc, gmii_rxd);
            if (byte_cnt != '1) byte_cnt <= byte_cnt + 11'd1;
            if (gmii_rx_er) rx_er_seen <= 1'b1;
            pipe[0] <= gmii_rxd;
            for (int unsigned i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
            // Once five bytes are held, pipe[4] is the oldest and leaves as this byte arrives.
            if (byte_cnt >= PIPE_DEPTH) begin
              out_valid   <= 1'b1;
              out_data    <= pipe[4];
              out_sop     <= sop_pending;
              sop_pending <= 1'b0;
            end
          end else begin
            state       <= IDLE;
            sop_pending <= 1'b0;
            // The four bytes still held are the FCS and are dropped here.
            if (byte_cnt >= PIPE_DEPTH) begin
              out_valid <= 1'b1;
              out_data  <= pipe[4];
              out_sop   <= sop_pending;
              out_eop   <= 1'b1;
              out_len   <= byte_cnt - 11'd4;
              out_err   <= frame_err;
              frame_ok  <= !frame_err;
              frame_bad <= frame_err;
            end else begin
              frame_bad <= 1'b1;
            end
          end
        end

        DROP: begin
          if (!gmii_rx_dv) begin
            state     <= IDLE;
            frame_bad <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      if (sfd_hit) begin
        crc         <= '1;
        byte_cnt    <= '0;
        rx_er_seen  <= 1'b0;
        sop_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Self-checking bench for gmii_rx_frame_parser: directed vector table, hand-written
// corner sequences and randomized frames against a frame-level reference model.
module tb_gmii_rx_frame_parser;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        gmii_rx_clk = 1'b0;
  logic        reset       = 1'b1;
  logic [7:0]  gmii_rxd    = '0;
  logic        gmii_rx_dv  = 1'b0;
  logic        gmii_rx_er  = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;
  logic [10:0] out_len;
  logic        frame_ok;
  logic        frame_bad;

  gmii_rx_frame_parser #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .gmii_rx_clk (gmii_rx_clk),
    .reset       (reset),
    .gmii_rxd    (gmii_rxd),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rx_er  (gmii_rx_er),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_err     (out_err),
    .out_len     (out_len),
    .frame_ok    (frame_ok),
    .frame_bad   (frame_bad)
  );

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  typedef struct packed {
    logic        valid;
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic        err;
    logic [10:0] len;
    logic        ok;
    logic        bad;
  } ev_t;

  typedef struct {
    string name;
    int    pre_len;
    bit    bad_pre;
    int    pay_len;
    bit    add_fcs;
    bit    fcs_flip;
    int    er_idx;
    int    exp_beats;
    int    exp_eops;
    int    exp_err;
    int    exp_len;
    int    exp_ok;
    int    exp_bad;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int cyc    = 0;
  int nprint = 0;

  logic [7:0] burst[$];
  bit         ber[$];
  ev_t        exp_q[$];
  ev_t        got_q[$];
  int         got_cyc[$];

  always @(posedge gmii_rx_clk) cyc <= cyc + 1;

  always @(negedge gmii_rx_clk) begin
    ev_t e;
    if (!reset) begin
      if (out_valid || frame_ok || frame_bad) begin
        e.valid = out_valid; e.data = out_data; e.sop = out_sop; e.eop = out_eop;
        e.err = out_err; e.len = out_len; e.ok = frame_ok; e.bad = frame_bad;
        got_q.push_back(e);
        got_cyc.push_back(cyc);
      end
      if ((!out_valid && (out_sop || out_eop || out_err || out_len != 0)) ||
          (out_valid && !out_eop && (out_err || out_len != 0 || frame_ok || frame_bad)) ||
          (frame_ok && frame_bad) || (frame_ok && !out_eop) ||
          (out_eop && !(frame_ok ^ frame_bad)))
        viol++;
    end
  end

  task automatic tick();
    @(posedge gmii_rx_clk);
    #1;
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame = pre_len x 0x55, SFD (or a bad byte), payload, optional FCS.
  task automatic build_frame(input int pre_len, input bit bad_pre, input int pay_len,
                             input bit rnd, input bit add_fcs, input bit fcs_flip, input int er_idx);
    logic [7:0]  pay[$];
    logic [31:0] c;
    logic [7:0]  bb;
    burst.delete();
    ber.delete();
    for (int k = 0; k < pre_len; k++) begin burst.push_back(8'h55); ber.push_back(1'b0); end
    if (bad_pre) begin
      bb = rnd ? 8'($urandom) : 8'hA5;
      if (bb == 8'h55 || bb == 8'hD5) bb = 8'h00;
      burst.push_back(bb);
    end else begin
      burst.push_back(8'hD5);
    end
    ber.push_back(1'b0);
    c = '1;
    for (int k = 0; k < pay_len; k++) begin
      bb = rnd ? 8'($urandom) : 8'(k);
      pay.push_back(bb);
      c = crc_step(c, bb);
    end
    c = ~c;
    if (fcs_flip) c[0] = ~c[0];
    if (add_fcs) for (int k = 0; k < 4; k++) pay.push_back(c[8*k +: 8]);
    for (int k = 0; k < pay.size(); k++) begin
      burst.push_back(pay[k]);
      ber.push_back(k == er_idx);
    end
  endtask

  // Reference: classify the whole burst, then list the beats the frame should produce.
  task automatic model_burst();
    int i, first, n, sat;
    bit er_any, err;
    logic [31:0] c, fcs;
    ev_t e;
    i = 0;
    while (i < burst.size() && !ber[i] && burst[i] == 8'h55) i++;
    if (i >= burst.size()) return;
    e = '0;
    if (ber[i] || burst[i] != 8'hD5) begin e.bad = 1'b1; exp_q.push_back(e); return; end
    first = i + 1;
    n = burst.size() - first;
    if (n < 5) begin e.bad = 1'b1; exp_q.push_back(e); return; end
    er_any = 1'b0;
    for (int k = 0; k < n; k++) er_any |= ber[first+k];
    c = '1;
    for (int k = 0; k < n - 4; k++) c = crc_step(c, burst[first+k]);
    c = ~c;
    fcs = {burst[first+n-1], burst[first+n-2], burst[first+n-3], burst[first+n-4]};
    err = (c != fcs) || (n < MIN_LEN) || (n > MAX_LEN) || er_any;
    sat = (n > 2047) ? 2047 : n;
    for (int k = 0; k < n - 4; k++) begin
      e = '0;
      e.valid = 1'b1;
      e.data  = burst[first+k];
      e.sop   = (k == 0);
      if (k == n - 5) begin
        e.eop = 1'b1; e.err = err; e.len = 11'(sat - 4); e.ok = !err; e.bad = err;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_burst(input int gap, input int mark_idx, output int mark_cyc);
    mark_cyc = -1;
    for (int k = 0; k < burst.size(); k++) begin
      gmii_rxd = burst[k]; gmii_rx_dv = 1'b1; gmii_rx_er = ber[k];
      if (k == mark_idx) mark_cyc = cyc;
      tick();
    end
    gmii_rxd = '0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic bit ev_match(input ev_t g, input ev_t x);
    if (g.valid != x.valid) return 1'b0;
    if (x.valid && g.data != x.data) return 1'b0;
    return g.sop == x.sop && g.eop == x.eop && g.err == x.err &&
           g.len == x.len && g.ok == x.ok && g.bad == x.bad;
  endfunction

  task automatic drain_compare(input string name);
    repeat (10) tick();
    check_int({name, " event count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (!ev_match(got_q[i], exp_q[i])) begin
        errors++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL %s ev%0d: got v%0b d%02h s%0b e%0b err%0b len%0d ok%0b bad%0b required v%0b d%02h s%0b e%0b err%0b len%0d ok%0b bad%0b",
                   name, i, got_q[i].valid, got_q[i].data, got_q[i].sop, got_q[i].eop, got_q[i].err,
                   got_q[i].len, got_q[i].ok, got_q[i].bad, exp_q[i].valid, exp_q[i].data, exp_q[i].sop,
                   exp_q[i].eop, exp_q[i].err, exp_q[i].len, exp_q[i].ok, exp_q[i].bad);
        end
      end
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check_int(name, {out_valid, out_data, out_sop, out_eop, out_err, out_len, frame_ok, frame_bad}, 0);
  endtask

  vec_t vecs[13];

  initial begin
    int mark, beats, eops, eerr, elen, oks, bads, sopf, first_valid, extra;

    vecs[0]  = '{"good",        7, 1'b0,   60, 1'b1, 1'b0, -1,   60, 1, 0,   60, 1, 0};
    vecs[1]  = '{"bad_fcs",     7, 1'b0,   60, 1'b1, 1'b1, -1,   60, 1, 1,   60, 0, 1};
    vecs[2]  = '{"rx_er_b10",   7, 1'b0,   60, 1'b1, 1'b0, 10,   60, 1, 1,   60, 0, 1};
    vecs[3]  = '{"runt40",      7, 1'b0,   40, 1'b1, 1'b0, -1,   40, 1, 1,   40, 0, 1};
    vecs[4]  = '{"burst3",      7, 1'b0,    3, 1'b0, 1'b0, -1,    0, 0, 0,    0, 0, 1};
    vecs[5]  = '{"bad_pre",     2, 1'b1,   17, 1'b0, 1'b0, -1,    0, 0, 0,    0, 0, 1};
    vecs[6]  = '{"short_pre",   0, 1'b0,   60, 1'b1, 1'b0, -1,   60, 1, 0,   60, 1, 0};
    vecs[7]  = '{"len63",       7, 1'b0,   59, 1'b1, 1'b0, -1,   59, 1, 1,   59, 0, 1};
    vecs[8]  = '{"len1518",     7, 1'b0, 1514, 1'b1, 1'b0, -1, 1514, 1, 0, 1514, 1, 0};
    vecs[9]  = '{"len1519",     7, 1'b0, 1515, 1'b1, 1'b0, -1, 1515, 1, 1, 1515, 0, 1};
    vecs[10] = '{"count5",      7, 1'b0,    1, 1'b1, 1'b0, -1,    1, 1, 1,    1, 0, 1};
    vecs[11] = '{"count4",      7, 1'b0,    0, 1'b1, 1'b0, -1,    0, 0, 0,    0, 0, 1};
    vecs[12] = '{"saturate",    1, 1'b0, 2100, 1'b0, 1'b0, -1, 2096, 1, 1, 2043, 0, 1};

    repeat (3) tick();
    @(negedge gmii_rx_clk);
    check_outputs_zero("reset state");
    reset = 1'b0;
    tick();

    foreach (vecs[v]) begin
      build_frame(vecs[v].pre_len, vecs[v].bad_pre, vecs[v].pay_len, 1'b0,
                  vecs[v].add_fcs, vecs[v].fcs_flip, vecs[v].er_idx);
      model_burst();
      drive_burst(4, vecs[v].pre_len + 1, mark);
      repeat (10) tick();
      beats = 0; eops = 0; eerr = 0; elen = 0; oks = 0; bads = 0; sopf = 0; first_valid = 1;
      foreach (got_q[i]) begin
        if (got_q[i].valid) begin
          beats++;
          if (first_valid) sopf = got_q[i].sop;
          first_valid = 0;
        end
        if (got_q[i].eop) begin eops++; eerr = got_q[i].err; elen = got_q[i].len; end
        oks  += got_q[i].ok;
        bads += got_q[i].bad;
      end
      check_int({vecs[v].name, " beats"},    beats, vecs[v].exp_beats);
      check_int({vecs[v].name, " eops"},     eops,  vecs[v].exp_eops);
      check_int({vecs[v].name, " out_err"},  eerr,  vecs[v].exp_err);
      check_int({vecs[v].name, " out_len"},  elen,  vecs[v].exp_len);
      check_int({vecs[v].name, " frame_ok"}, oks,   vecs[v].exp_ok);
      check_int({vecs[v].name, " frame_bad"}, bads, vecs[v].exp_bad);
      check_int({vecs[v].name, " sop first"}, sopf, vecs[v].exp_beats > 0);
      drain_compare(vecs[v].name);
    end

    // Latency from payload byte presented to its appearance on out_data.
    build_frame(7, 1'b0, 60, 1'b0, 1'b1, 1'b0, -1);
    model_burst();
    drive_burst(4, 8, mark);
    repeat (10) tick();
    check_int("latency", (got_cyc.size() > 0) ? got_cyc[0] - mark : -1, 6);
    drain_compare("latency frame");

    // Back-to-back frames with a single idle cycle between them.
    build_frame(7, 1'b0, 60, 1'b0, 1'b1, 1'b0, -1);
    model_burst();
    drive_burst(1, -1, mark);
    build_frame(7, 1'b0, 60, 1'b1, 1'b1, 1'b0, -1);
    model_burst();
    drive_burst(4, -1, mark);
    repeat (10) tick();
    oks = 0;
    foreach (got_q[i]) oks += got_q[i].ok;
    check_int("gap1 frame_ok count", oks, 2);
    drain_compare("gap1 pair");

    // Reset mid-payload: frame silently abandoned, next frame parsed normally.
    build_frame(7, 1'b0, 60, 1'b0, 1'b1, 1'b0, -1);
    for (int k = 0; k < 28; k++) begin
      gmii_rxd = burst[k]; gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0;
      tick();
    end
    reset = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = '0;
    tick();
    @(negedge gmii_rx_clk);
    check_outputs_zero("reset mid-frame outputs");
    got_q.delete();
    got_cyc.delete();
    reset = 1'b0;
    repeat (10) tick();
    check_int("reset mid-frame events", got_q.size(), 0);
    build_frame(3, 1'b0, 60, 1'b1, 1'b1, 1'b0, -1);
    model_burst();
    drive_burst(4, -1, mark);
    drain_compare("after reset");

    // Randomized frames with short gaps.
    for (int f = 0; f < 40; f++) begin
      int plen;
      extra = $urandom_range(0, 9);
      plen  = (extra == 0) ? $urandom_range(1500, 1530) : $urandom_range(0, 70);
      build_frame($urandom_range(0, 7), ($urandom_range(0, 9) == 0), plen, 1'b1,
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0 && plen > 0) ? $urandom_range(0, plen - 1) : -1);
      model_burst();
      drive_burst($urandom_range(1, 3), -1, mark);
    end
    drain_compare("random");

    check_int("idle-output protocol violations", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
